// File: rtl/snn_lif_core.sv
// snn_lif_core: N_IN spike inputs, SPI-programmable signed weights, and N_OUT
// leaky integrate-and-fire neurons with threshold, leak and refractory period.
module snn_lif_core #(
    parameter int N_IN     = 3,
    parameter int N_OUT    = 3,
    parameter int V_W      = 8,
    parameter int TICK_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [N_IN-1:0]  spikes_in_async,
    output logic [N_OUT-1:0] spikes_out
);

    localparam int N_W   = N_IN * N_OUT;
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int S_W   = V_W + 8 + $clog2(N_IN) + 2;
    localparam logic [V_W-1:0] V_MAX = '1;

    // Input synchroniser, SPI pin synchroniser and SPI frame state
    logic [N_IN-1:0] spk_q0, spk_q1, spk_q2, pending;
    logic [2:0]      sclk_q;
    logic [1:0]      cs_q, mosi_q;
    logic [4:0]      bit_cnt;
    logic [14:0]     shift;
    logic [7:0]      tx;
    logic            spi_armed;

    // Programmable registers
    logic [7:0] w [N_W];
    logic [7:0] thr, leak, refr, ctrl;

    // Neuron state
    logic [CNT_W-1:0] tick_cnt;
    logic [V_W-1:0]   v [N_OUT];
    logic [7:0]       rc [N_OUT];

    logic             tick, run;
    logic [N_IN-1:0]  spk_edge;
    logic             sclk_rise, sclk_fall, wr_en;
    logic [6:0]       wr_addr, rd_addr;
    logic [7:0]       wr_data, rdata;
    logic [V_W-1:0]   v_cand [N_OUT];
    logic [N_OUT-1:0] fire_c;

    assign spk_edge  = spk_q1 & ~spk_q2;
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign run       = ena & ctrl[0];
    assign tick      = run && (tick_cnt == CNT_W'(TICK_DIV - 1));

    // Write commits on the 16th rise; shift then holds frame[15:1], mosi is frame[0]
    assign wr_en   = !cs_q[1] && spi_armed && sclk_rise && (bit_cnt == 5'd15) && shift[14];
    assign wr_addr = shift[13:7];
    assign wr_data = {shift[6:0], mosi_q[1]};
    // Read address is complete on the 8th rise: shift[5:0] plus the current mosi bit
    assign rd_addr = {shift[5:0], mosi_q[1]};

    // Synchronise async pins and collect input spike edges between ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_q0  <= '0;
            spk_q1  <= '0;
            spk_q2  <= '0;
            pending <= '0;
            sclk_q  <= '0;
            cs_q    <= 2'b11;
            mosi_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old value of
            // its predecessor, which is what turns this chain into a synchroniser.
            spk_q0  <= spikes_in_async;
            spk_q1  <= spk_q0;
            spk_q2  <= spk_q1;
            // An edge arriving in the tick cycle survives into the next timestep
            pending <= tick ? spk_edge : (pending | spk_edge);
            sclk_q  <= {sclk_q[1:0], sclk};
            cs_q    <= {cs_q[0], cs_n};
            mosi_q  <= {mosi_q[0], mosi};
        end
    end

    // Register read mux for the SPI read path
    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch is inferred.
        rdata = 8'h00;
        for (int k = 0; k < N_W; k++)
            if (rd_addr == 7'(k)) rdata = w[k];
        case (rd_addr)
            7'h40:   rdata = thr;
            7'h41:   rdata = leak;
            7'h42:   rdata = refr;
            7'h43:   rdata = ctrl;
            7'h44:   rdata = 8'(spikes_out);
            default: ;
        endcase
    end

    // SPI frame engine: bit counter, shift-in on rise, shift-out on fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift     <= '0;
            tx        <= '0;
            miso      <= 1'b0;
            spi_armed <= 1'b0;
        end else if (cs_q[1]) begin
            // Only a deselect arms the engine, so a reset mid-frame drops that frame
            bit_cnt   <= '0;
            miso      <= 1'b0;
            spi_armed <= 1'b1;
        end else if (spi_armed) begin
            if (sclk_rise && bit_cnt != 5'd16) begin
                shift   <= {shift[13:0], mosi_q[1]};
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd7)
                    tx <= rdata;
            end
            if (sclk_fall && bit_cnt >= 5'd8 && bit_cnt <= 5'd15) begin
                miso <= tx[7];
                tx   <= {tx[6:0], 1'b0};
            end
        end
    end

    // Register file writes from completed SPI write frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the weight array is a few flops, not a RAM, so it is reset
            // like any other register to give a known all-zero network.
            for (int k = 0; k < N_W; k++)
                w[k] <= '0;
            thr  <= 8'h40;
            leak <= 8'h01;
            refr <= 8'h02;
            ctrl <= 8'h01;
        end else if (wr_en) begin
            for (int k = 0; k < N_W; k++)
                if (wr_addr == 7'(k)) w[k] <= wr_data;
            case (wr_addr)
                7'h40:   thr  <= wr_data;
                7'h41:   leak <= wr_data;
                7'h42:   refr <= wr_data;
                7'h43:   ctrl <= wr_data;
                default: ;
            endcase
        end
    end

    // Candidate membrane potential and fire decision for each neuron
    always_comb begin
        logic signed [S_W-1:0] acc;
        logic [S_W-1:0]        sat;
        fire_c = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc = $signed(S_W'(v[j]));
            for (int i = 0; i < N_IN; i++)
                if (pending[i]) acc = acc + S_W'($signed(w[i*N_OUT + j]));
            acc = acc - $signed(S_W'(leak));
            if (acc[S_W-1])
                sat = '0;
            else if (acc > $signed(S_W'(V_MAX)))
                sat = S_W'(V_MAX);
            else
                sat = acc;
            v_cand[j] = sat[V_W-1:0];
            fire_c[j] = (sat >= S_W'(thr));
        end
    end

    // Timestep counter and neuron state update at each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            spikes_out <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                v[j]  <= '0;
                rc[j] <= '0;
            end
        end else begin
            if (run)
                tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            if (tick) begin
                for (int j = 0; j < N_OUT; j++) begin
                    if (rc[j] != 8'd0) begin
                        rc[j]         <= rc[j] - 8'd1;
                        v[j]          <= '0;
                        spikes_out[j] <= 1'b0;
                    end else if (fire_c[j]) begin
                        rc[j]         <= refr;
                        v[j]          <= '0;
                        spikes_out[j] <= 1'b1;
                    end else begin
                        v[j]          <= v_cand[j];
                        spikes_out[j] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_snn_lif_core.sv
// Directed testbench for snn_lif_core: SPI register access and neuron behaviour.
module tb_snn_lif_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [2:0] spikes_in = '0;
    logic [2:0] spikes_out;
    logic [7:0] rx;

    int n_vec = 0;
    int n_err = 0;

    snn_lif_core #(.N_IN(3), .N_OUT(3), .V_W(8), .TICK_DIV(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena             (ena),
        .sclk            (sclk),
        .cs_n            (cs_n),
        .mosi            (mosi),
        .miso            (miso),
        .spikes_in_async (spikes_in),
        .spikes_out      (spikes_out)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        ena = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; spikes_in = '0;
        rst_n = 1'b0;
        #25 rst_n = 1'b1;
        #30;
    endtask

    // SPI mode-0 frame; stops after nbits, pulses rst_n before bit rst_bit (-1 = never)
    task automatic spi_frame(input logic [15:0] frame, input int nbits, input int rst_bit,
                             output logic [7:0] rd);
        rd = '0;
        cs_n = 1'b0;
        #50;
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_bit) begin
                rst_n = 1'b0;
                #20 rst_n = 1'b1;
            end
            mosi = frame[15-k];
            #50;
            if (k >= 8) rd[15-k] = miso;
            sclk = 1'b1;
            #50 sclk = 1'b0;
        end
        #50 cs_n = 1'b1;
        #100;
    endtask

    task automatic spi_wr(input logic [6:0] addr, input logic [7:0] data);
        logic [7:0] dummy;
        spi_frame({1'b1, addr, data}, 16, -1, dummy);
    endtask

    task automatic spi_rd(input logic [6:0] addr, output logic [7:0] data);
        spi_frame({1'b0, addr, 8'h00}, 16, -1, data);
    endtask

    task automatic pulse(input int i);
        @(negedge clk) spikes_in[i] = 1'b1;
        repeat (5) @(negedge clk);
        spikes_in[i] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // One timestep: counter starts frozen at 0, runs 16 cycles, ticks, freezes again
    task automatic step();
        @(negedge clk) ena = 1'b1;
        repeat (16) @(negedge clk);
        ena = 1'b0;
    endtask

    // Timestep with input 0 rising so its edge is detected exactly in the tick cycle
    task automatic step_late_edge();
        @(negedge clk) ena = 1'b1;
        repeat (13) @(negedge clk);
        spikes_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        ena = 1'b0;
        repeat (4) @(negedge clk);
        spikes_in[0] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        // Reset defaults
        do_reset();
        check("rst_spikes", spikes_out, 3'b000);
        check("rst_miso", miso, 1'b0);
        spi_rd(7'h40, rx); check("def_thr", rx, 8'h40);
        spi_rd(7'h41, rx); check("def_leak", rx, 8'h01);
        spi_rd(7'h42, rx); check("def_refr", rx, 8'h02);
        spi_rd(7'h43, rx); check("def_ctrl", rx, 8'h01);
        spi_rd(7'h00, rx); check("def_w0", rx, 8'h00);
        spi_rd(7'h08, rx); check("def_w8", rx, 8'h00);
        spi_rd(7'h7F, rx); check("unmapped", rx, 8'h00);
        check("miso_idle", miso, 1'b0);

        // Single-synapse fire, refractory, read-only spike register
        do_reset();
        spi_wr(7'h00, 8'h50);
        spi_wr(7'h41, 8'h00);
        spi_wr(7'h44, 8'hFF);
        spi_rd(7'h00, rx); check("w0_rb", rx, 8'h50);
        pulse(0); step(); check("fire_t1", spikes_out, 3'b001);
        spi_rd(7'h44, rx); check("spk_reg", rx, 8'h01);
        pulse(0); step(); check("refr_t2", spikes_out, 3'b000);
        pulse(0); step(); check("refr_t3", spikes_out, 3'b000);
        step(); check("quiet_t4", spikes_out, 3'b000);
        pulse(0); step(); check("fire_t5", spikes_out, 3'b001);

        // Integration with leak: 0x18, 0x30, 0x48 -> fire on the third timestep
        do_reset();
        spi_wr(7'h05, 8'h20);
        spi_wr(7'h41, 8'h08);
        pulse(1); step(); check("int_t1", spikes_out, 3'b000);
        pulse(1); step(); check("int_t2", spikes_out, 3'b000);
        pulse(1); step(); check("int_t3", spikes_out, 3'b100);

        // Negative weight clamps at 0; a following +0x3F stays below threshold
        do_reset();
        spi_wr(7'h01, 8'h80);
        spi_wr(7'h41, 8'h00);
        pulse(0); step(); check("neg_t1", spikes_out, 3'b000);
        spi_wr(7'h01, 8'h3F);
        pulse(0); step(); check("neg_t2", spikes_out, 3'b000);

        // Saturation: 0x7F, 0xFE, then 0x17D saturates to 0xFF = thr -> fire
        do_reset();
        spi_wr(7'h01, 8'h7F);
        spi_wr(7'h40, 8'hFF);
        spi_wr(7'h41, 8'h00);
        pulse(0); step(); check("sat_t1", spikes_out, 3'b000);
        pulse(0); step(); check("sat_t2", spikes_out, 3'b000);
        pulse(0); step(); check("sat_t3", spikes_out, 3'b010);

        // Tick enable bit gates the timestep; pending is held meanwhile
        do_reset();
        spi_wr(7'h00, 8'h50);
        spi_wr(7'h43, 8'h00);
        pulse(0); step(); check("ctrl_off", spikes_out, 3'b000);
        spi_wr(7'h43, 8'h01);
        step(); check("ctrl_on", spikes_out, 3'b001);

        // Edge in the tick cycle counts in the next timestep
        do_reset();
        spi_wr(7'h00, 8'h50);
        spi_wr(7'h41, 8'h00);
        step_late_edge(); check("late_t1", spikes_out, 3'b000);
        step(); check("late_t2", spikes_out, 3'b001);

        // Two edges in one window count once: 0x30, then 0x60 fires
        do_reset();
        spi_wr(7'h00, 8'h30);
        spi_wr(7'h41, 8'h00);
        pulse(0); pulse(0); step(); check("dbl_t1", spikes_out, 3'b000);
        pulse(0); step(); check("dbl_t2", spikes_out, 3'b001);

        // Aborted frame writes nothing; the next full frame succeeds
        do_reset();
        spi_frame({1'b1, 7'h40, 8'h77}, 10, -1, rx);
        spi_rd(7'h40, rx); check("abort_thr", rx, 8'h40);
        spi_wr(7'h40, 8'h33);
        spi_rd(7'h40, rx); check("full_thr", rx, 8'h33);

        // Reset during SPI bit 12 with a pending spike
        do_reset();
        spi_wr(7'h00, 8'h50);
        spi_wr(7'h41, 8'h00);
        pulse(0);
        spi_frame({1'b1, 7'h40, 8'h77}, 16, 12, rx);
        check("mid_rst_spk", spikes_out, 3'b000);
        spi_rd(7'h40, rx); check("mid_rst_thr", rx, 8'h40);
        spi_rd(7'h00, rx); check("mid_rst_w0", rx, 8'h00);
        step(); check("mid_rst_pend", spikes_out, 3'b000);
        spi_wr(7'h42, 8'h05);
        spi_rd(7'h42, rx); check("post_rst_wr", rx, 8'h05);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2ms;
        $display("FAIL timeout: got no finish, expected finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule
